// File: rtl/edge_window_controller.sv
// Sequences one edge-measurement run: drives a programmable high/low waveform
// and counts its rising/falling edges over a fixed window of clk cycles.
module edge_window_controller #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] high_cycles,
  input  logic [DIV_W-1:0] low_cycles,
  input  logic [CNT_W-1:0] window_cycles,
  output logic             wave_out,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] fall_count,
  output logic [CNT_W-1:0] elapsed
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] high_q, high_d;
  logic [DIV_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] window_q, window_d;
  logic [DIV_W-1:0] phase_cnt_q, phase_cnt_d;
  logic             phase_high_q, phase_high_d;
  logic             wave_d, busy_d, done_d, cfg_err_d;
  logic [CNT_W-1:0] rise_d, fall_d, elapsed_d;

  logic             cfg_ok;
  logic             last_cycle;
  logic [DIV_W-1:0] high_m1, low_m1;

  assign cfg_ok     = (|high_cycles) && (|low_cycles) && (|window_cycles);
  assign high_m1    = high_q - DIV_W'(1);
  assign low_m1     = low_q - DIV_W'(1);
  assign last_cycle = (elapsed == (window_q - CNT_W'(1)));

  // Next-state and next-output logic; every registered value defaults to hold.
  always_comb begin
    state_d      = state_q;
    high_d       = high_q;
    low_d        = low_q;
    window_d     = window_q;
    phase_cnt_d  = phase_cnt_q;
    phase_high_d = phase_high_q;
    wave_d       = wave_out;
    rise_d       = rise_count;
    fall_d       = fall_count;
    elapsed_d    = elapsed;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            high_d       = high_cycles;
            low_d        = low_cycles;
            window_d     = window_cycles;
            phase_cnt_d  = '0;
            phase_high_d = 1'b0;
            wave_d       = 1'b0;
            rise_d       = '0;
            fall_d       = '0;
            elapsed_d    = '0;
            busy_d       = 1'b1;
            state_d      = S_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        elapsed_d = elapsed + CNT_W'(1);
        if (!phase_high_q) begin
          if (phase_cnt_q == low_m1) begin
            wave_d       = 1'b1;
            rise_d       = rise_count + CNT_W'(1);
            phase_high_d = 1'b1;
            phase_cnt_d  = '0;
          end else begin
            phase_cnt_d = phase_cnt_q + DIV_W'(1);
          end
        end else begin
          if (phase_cnt_q == high_m1) begin
            wave_d       = 1'b0;
            fall_d       = fall_count + CNT_W'(1);
            phase_high_d = 1'b0;
            phase_cnt_d  = '0;
          end else begin
            phase_cnt_d = phase_cnt_q + DIV_W'(1);
          end
        end

        // Abort takes priority over completion; the final-cycle edge is still
        // counted but the waveform is parked low.
        if (abort) begin
          wave_d  = 1'b0;
          state_d = S_IDLE;
        end else if (last_cycle) begin
          wave_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      high_q       <= '0;
      low_q        <= '0;
      window_q     <= '0;
      phase_cnt_q  <= '0;
      phase_high_q <= 1'b0;
      wave_out     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      rise_count   <= '0;
      fall_count   <= '0;
      elapsed      <= '0;
    end else begin
      state_q      <= state_d;
      high_q       <= high_d;
      low_q        <= low_d;
      window_q     <= window_d;
      phase_cnt_q  <= phase_cnt_d;
      phase_high_q <= phase_high_d;
      wave_out     <= wave_d;
      busy         <= busy_d;
      done         <= done_d;
      cfg_err      <= cfg_err_d;
      rise_count   <= rise_d;
      fall_count   <= fall_d;
      elapsed      <= elapsed_d;
    end
  end

endmodule

// File: tb/tb_edge_window_controller.sv
// Directed bench for edge_window_controller with hand-computed expectations.
module tb_edge_window_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] high_cycles;
  logic [15:0] low_cycles;
  logic [31:0] window_cycles;
  logic        wave_out;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [31:0] rise_count;
  logic [31:0] fall_count;
  logic [31:0] elapsed;

  int n_checks = 0;
  int n_pass   = 0;

  edge_window_controller #(.CNT_W(32), .DIV_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .high_cycles  (high_cycles),
    .low_cycles   (low_cycles),
    .window_cycles(window_cycles),
    .wave_out     (wave_out),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err),
    .rise_count   (rise_count),
    .fall_count   (fall_count),
    .elapsed      (elapsed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  // Drives start for one cycle from a negedge; returns at the first RUN cycle.
  task automatic start_run(input int h, input int l, input int w);
    high_cycles   = 16'(h);
    low_cycles    = 16'(l);
    window_cycles = 32'(w);
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
  endtask

  // Counts negedges (cycle index relative to start) until done, bounded.
  task automatic wait_done(input int n0, input int max, output int n);
    n = n0;
    while (!done && n <= max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_results(input string tag, input int r, input int f, input int e);
    chk({tag, "_rise"}, rise_count, 32'(r));
    chk({tag, "_fall"}, fall_count, 32'(f));
    chk({tag, "_elapsed"}, elapsed, 32'(e));
  endtask

  int n;
  int exp_wave[6] = '{0, 1, 0, 1, 0, 0};

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    high_cycles = '0;
    low_cycles = '0;
    window_cycles = '0;
    repeat (2) @(negedge clk);
    chk("rst_flags", 32'({wave_out, busy, done, cfg_err}), 32'd0);
    chk("rst_counts", rise_count | fall_count | elapsed, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Scenario 1: nominal run.
    start_run(3, 7, 100);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_wave0", 32'(wave_out), 32'd0);
    wait_done(1, 200, n);
    chk("s1_done_lat", 32'(n), 32'd101);
    chk("s1_busy_done", 32'(busy), 32'd0);
    chk("s1_wave_done", 32'(wave_out), 32'd0);
    chk_results("s1", 10, 10, 100);
    @(negedge clk);
    chk("s1_done_pulse", 32'(done), 32'd0);

    // Scenario 2: fastest toggling, wave sampled each cycle.
    start_run(1, 1, 5);
    chk("s2_wave_c1", 32'(wave_out), 32'd0);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("s2_wave_c%0d", k), 32'(wave_out), 32'(exp_wave[k-1]));
    end
    chk("s2_done", 32'(done), 32'd1);
    chk_results("s2", 3, 2, 5);
    @(negedge clk);

    // Scenario 3: invalid config rejected.
    start_run(3, 0, 100);
    chk("s3_cfg_err", 32'(cfg_err), 32'd1);
    chk("s3_busy", 32'(busy), 32'd0);
    chk_results("s3", 3, 2, 5);
    @(negedge clk);
    chk("s3_cfg_err_pulse", 32'(cfg_err), 32'd0);
    chk("s3_busy2", 32'(busy), 32'd0);

    // Scenario 4: abort while elapsed==50.
    start_run(3, 7, 100);
    n = 1;
    while (n < 51) begin
      @(negedge clk);
      n++;
    end
    chk("s4_elapsed_at_abort", elapsed, 32'd50);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("s4_busy", 32'(busy), 32'd0);
    chk("s4_done", 32'(done), 32'd0);
    chk("s4_wave", 32'(wave_out), 32'd0);
    chk_results("s4", 5, 5, 51);
    repeat (3) @(negedge clk);
    chk("s4_no_done", 32'(done), 32'd0);
    chk("s4_hold", elapsed, 32'd51);

    // Scenario 5: asynchronous reset mid-run, then a clean rerun.
    start_run(3, 7, 100);
    repeat (29) @(negedge clk);
    chk("s5_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("s5_rst_flags", 32'({wave_out, busy, done, cfg_err}), 32'd0);
    chk("s5_rst_counts", rise_count | fall_count | elapsed, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("s5_idle_done", 32'(done), 32'd0);
    start_run(3, 7, 100);
    wait_done(1, 200, n);
    chk("s5_done_lat", 32'(n), 32'd101);
    chk_results("s5", 10, 10, 100);
    @(negedge clk);

    // Scenario 6: start pulsed in RUN (with altered config) and in DONE.
    start_run(3, 7, 100);
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      n++;
    end
    high_cycles = 16'd1;
    low_cycles = 16'd1;
    window_cycles = 32'd5;
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    wait_done(n, 200, n);
    chk("s6_done_lat", 32'(n), 32'd101);
    chk_results("s6", 10, 10, 100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s6_no_restart", 32'(busy), 32'd0);
    chk_results("s6_post", 10, 10, 100);
    @(negedge clk);
    chk("s6_still_idle", 32'(busy), 32'd0);

    // Abort on the final RUN cycle beats completion.
    start_run(1, 1, 5);
    repeat (4) @(negedge clk);
    chk("ab_last_elapsed", elapsed, 32'd4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_last_done", 32'(done), 32'd0);
    chk("ab_last_busy", 32'(busy), 32'd0);
    chk_results("ab_last", 3, 2, 5);
    @(negedge clk);
    chk("ab_last_no_done", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
